svv_lmb_spi_slave: RTL and testbench

//  SPI slave peripheral on the MicroBlaze LMB bus; the other end of the LMB SPI master link.

---
 rtl/svv_lmb_spi_slave_if.sv | 25 ++
 rtl/svv_lmb_spi_slave.sv | 233 +++++++++++++++++++++++
 tb/tb_svv_lmb_spi_slave.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/svv_lmb_spi_slave_if.sv
// LMB slave-side bus bundle for the SPI slave peripheral.
// The master modport is the bus (or bench) side; the slave modport is the peripheral side.
interface svv_lmb_spi_slave_if;
   logic [31:0] LMB_ABus;
   logic        LMB_AddrStrobe;
   logic [3:0]  LMB_BE;
   logic        LMB_ReadStrobe;
   logic        LMB_WriteStrobe;
   logic [31:0] LMB_WriteDBus;
   logic [31:0] Sl_DBus;
   logic        Sl_Ready;
   logic        Sl_Wait;
   logic        Sl_UE;
   logic        Sl_CE;

   modport slave (
      input  LMB_ABus, LMB_AddrStrobe, LMB_BE, LMB_ReadStrobe, LMB_WriteStrobe, LMB_WriteDBus,
      output Sl_DBus, Sl_Ready, Sl_Wait, Sl_UE, Sl_CE
   );

   modport master (
      output LMB_ABus, LMB_AddrStrobe, LMB_BE, LMB_ReadStrobe, LMB_WriteStrobe, LMB_WriteDBus,
      input  Sl_DBus, Sl_Ready, Sl_Wait, Sl_UE, Sl_CE
   );
endinterface

// File: rtl/svv_lmb_spi_slave.sv
// SPI slave peripheral on the MicroBlaze LMB bus.
// SCLK/MOSI/SS are oversampled into slmb_aclk (needs f(aclk) >= 4*f(SCLK)); frames of
// 1..32 bits, MSB first, all four CPOL/CPHA modes. Registers: CR, SR, RXDR, TXDR.
module svv_lmb_spi_slave #(
   parameter logic [31:0] ADDRES      = 32'hC4000000,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                      slmb_aclk,
   input  logic                      slmb_aresetn,
   svv_lmb_spi_slave_if.slave        lmb,
   input  logic                      SCLK,
   input  logic                      MOSI,
   input  logic                      SS,
   output logic                      MISO,
   output logic                      MISO_T,
   output logic                      IRQ
);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   localparam logic [31:0] CR_RESET = 32'h0000_1F00;
   localparam logic [31:0] CR_WMASK = 32'h0000_1F1B;

   // Byte-enable merge of a write into a register, restricted to its writable bits.
   function automatic logic [31:0] f_be_merge(input logic [31:0] old_v, input logic [31:0] wd,
                                              input logic [3:0] be, input logic [31:0] wmask);
      logic [31:0] m;
      m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}} & wmask;
      return (old_v & ~m) | (wd & m);
   endfunction

   // synchronisers and edge-detect history
   logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_ss_sync;
   logic                   r_sclk_d, r_ss_d;
   logic                   w_sclk_s, w_mosi_s, w_ss_s;
   logic                   w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;

   // registers
   logic [31:0] r_cr, r_txdr, r_rxdr;
   logic        r_rxv, r_txe, r_ovr, r_udr;

   // bus response
   logic        r_ready;
   logic [31:0] r_dbus;
   logic        w_hit, w_rd, w_wr;
   logic [2:0]  w_sel;
   logic [31:0] w_rdata;
   logic        w_wr_cr, w_wr_sr, w_wr_tx, w_rd_rx;
   logic        w_unused_abus;

   // SPI engine
   state_t      r_state, w_state_nxt;
   logic        r_cpol, r_cpha;
   logic [4:0]  r_len, r_bitcnt;
   logic [31:0] r_tx_shift;
   logic [30:0] r_rx_shift;
   logic [31:0] w_rx_word;
   logic        w_lead, w_trail;
   logic        w_ss_load, w_sample, w_advance, w_frame_end, w_tx_load;

   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
   assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
   assign w_ss_fall   = ~w_ss_s & r_ss_d;
   assign w_ss_rise   = w_ss_s & ~r_ss_d;

   // Bring the SPI pins into the aclk domain and keep one cycle of history for edges.
   always_ff @(posedge slmb_aclk or negedge slmb_aresetn) begin
      if (!slmb_aresetn) begin
         r_sclk_sync <= '0;
         r_mosi_sync <= '0;
         r_ss_sync   <= '1;
         r_sclk_d    <= 1'b0;
         r_ss_d      <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
         r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS};
         r_sclk_d    <= w_sclk_s;
         r_ss_d      <= w_ss_s;
      end
   end

   // ---------------- LMB decode ----------------
   assign w_hit   = lmb.LMB_AddrStrobe & (lmb.LMB_ABus[31:5] == ADDRES[31:5]);
   assign w_rd    = w_hit & lmb.LMB_ReadStrobe;
   assign w_wr    = w_hit & lmb.LMB_WriteStrobe;
   assign w_sel   = lmb.LMB_ABus[4:2];
   assign w_wr_cr = w_wr & (w_sel == 3'd0);
   assign w_wr_sr = w_wr & (w_sel == 3'd1) & lmb.LMB_BE[0];
   assign w_wr_tx = w_wr & (w_sel == 3'd3);
   assign w_rd_rx = w_rd & (w_sel == 3'd2);
   assign w_unused_abus = ^lmb.LMB_ABus[1:0];

   // Register read multiplexer; BUSY mirrors the synchronised slave select.
   always_comb begin
      w_rdata = '0;
      case (w_sel)
         3'd0:    w_rdata = r_cr;
         3'd1:    w_rdata = {27'd0, r_udr, ~w_ss_s, r_ovr, r_txe, r_rxv};
         3'd2:    w_rdata = r_rxdr;
         3'd3:    w_rdata = r_txdr;
         default: w_rdata = '0;
      endcase
   end

   // Acknowledge one cycle after a decoded strobe; read data only in that cycle.
   always_ff @(posedge slmb_aclk or negedge slmb_aresetn) begin
      if (!slmb_aresetn) begin
         r_ready <= 1'b0;
         r_dbus  <= '0;
      end else begin
         r_ready <= w_hit;
         r_dbus  <= w_rd ? w_rdata : '0;
      end
   end

   assign lmb.Sl_Ready = r_ready;
   assign lmb.Sl_DBus  = r_dbus;
   assign lmb.Sl_Wait  = 1'b0;
   assign lmb.Sl_UE    = 1'b0;
   assign lmb.Sl_CE    = 1'b0;

   // ---------------- SPI engine ----------------
   assign w_lead      = r_cpol ? w_sclk_fall : w_sclk_rise;
   assign w_trail     = r_cpol ? w_sclk_rise : w_sclk_fall;
   assign w_frame_end = w_sample & (r_bitcnt == r_len);
   assign w_tx_load   = w_ss_load | w_frame_end;
   assign w_rx_word   = {r_rx_shift, w_mosi_s};

   // Engine state register.
   always_ff @(posedge slmb_aclk or negedge slmb_aresetn) begin
      if (!slmb_aresetn) r_state <= S_IDLE;
      else               r_state <= w_state_nxt;
   end

   // Next state and per-cycle engine strobes (sample MOSI / advance MISO).
   always_comb begin
      w_state_nxt = r_state;
      w_ss_load   = 1'b0;
      w_sample    = 1'b0;
      w_advance   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_ss_fall) begin
               w_state_nxt = S_ACTIVE;
               w_ss_load   = 1'b1;
            end
         end
         S_ACTIVE: begin
            if (w_ss_rise) begin
               w_state_nxt = S_IDLE;
            end else begin
               if (w_lead) begin
                  if (r_cpha) w_advance = 1'b1;
                  else        w_sample  = 1'b1;
               end
               if (w_trail) begin
                  if (r_cpha) w_sample  = 1'b1;
                  else        w_advance = 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Shifters and bit counter. The first advance edge of a frame is skipped so the
   // MSB loaded at the frame start stays on MISO until the master has taken it.
   always_ff @(posedge slmb_aclk or negedge slmb_aresetn) begin
      if (!slmb_aresetn) begin
         r_cpol     <= 1'b0;
         r_cpha     <= 1'b0;
         r_len      <= 5'd31;
         r_bitcnt   <= '0;
         r_tx_shift <= '0;
         r_rx_shift <= '0;
      end else begin
         if (w_ss_load) begin
            r_cpol <= r_cr[1];
            r_cpha <= r_cr[0];
            r_len  <= r_cr[12:8];
         end
         if (w_tx_load) begin
            r_bitcnt   <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= r_txe ? 32'd0 : r_txdr;
         end else begin
            if (w_sample) begin
               r_rx_shift <= w_rx_word[30:0];
               r_bitcnt   <= r_bitcnt + 5'd1;
            end
            if (w_advance && (r_bitcnt != 5'd0)) r_tx_shift <= r_tx_shift << 1;
         end
      end
   end

   // Control/status registers; later assignments give engine events or bus writes priority.
   always_ff @(posedge slmb_aclk or negedge slmb_aresetn) begin
      if (!slmb_aresetn) begin
         r_cr   <= CR_RESET;
         r_txdr <= '0;
         r_rxdr <= '0;
         r_rxv  <= 1'b0;
         r_txe  <= 1'b1;
         r_ovr  <= 1'b0;
         r_udr  <= 1'b0;
      end else begin
         if (w_wr_cr) r_cr   <= f_be_merge(r_cr, lmb.LMB_WriteDBus, lmb.LMB_BE, CR_WMASK);
         if (w_wr_tx) r_txdr <= f_be_merge(r_txdr, lmb.LMB_WriteDBus, lmb.LMB_BE, 32'hFFFF_FFFF);
         if (w_rd_rx) r_rxv <= 1'b0;
         if (w_wr_sr && lmb.LMB_WriteDBus[2]) r_ovr <= 1'b0;
         if (w_wr_sr && lmb.LMB_WriteDBus[4]) r_udr <= 1'b0;
         if (w_frame_end) begin
            r_rxdr <= w_rx_word;
            r_rxv  <= 1'b1;
            if (r_rxv && !w_rd_rx) r_ovr <= 1'b1;
         end
         if (w_tx_load) begin
            r_txe <= 1'b1;
            if (r_txe) r_udr <= 1'b1;
         end
         if (w_wr_tx) r_txe <= 1'b0;
      end
   end

   assign MISO   = r_tx_shift[r_len];
   assign MISO_T = w_ss_s;
   assign IRQ    = (r_rxv & r_cr[3]) | (r_txe & r_cr[4]);

endmodule

// File: tb/tb_svv_lmb_spi_slave.sv
// Bench for svv_lmb_spi_slave: an LMB bus driver plus a bit-level SPI master, checked
// against a register/frame model built from the peripheral's rules.
module tb_svv_lmb_spi_slave;
   localparam logic [31:0] BASE = 32'hC4000000;
   localparam int          H    = 60;   // SCLK half period (6 aclk cycles)

   logic clk = 1'b0;
   logic rst_n;
   logic SCLK, MOSI, SS;
   logic MISO, MISO_T, IRQ;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   bit          m_rxv, m_txe, m_ovr, m_udr;
   logic [31:0] m_rxdr, m_txdr, m_cr;

   svv_lmb_spi_slave_if lmb();

   svv_lmb_spi_slave #(.ADDRES(BASE), .SYNC_STAGES(2)) dut (
      .slmb_aclk   (clk),
      .slmb_aresetn(rst_n),
      .lmb         (lmb),
      .SCLK        (SCLK),
      .MOSI        (MOSI),
      .SS          (SS),
      .MISO        (MISO),
      .MISO_T      (MISO_T),
      .IRQ         (IRQ)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_rxv = 0; m_txe = 1; m_ovr = 0; m_udr = 0;
      m_rxdr = 0; m_txdr = 0; m_cr = 32'h0000_1F00;
   endtask

   // One LMB access; checks the single-cycle acknowledge and the idle bus afterwards.
   task automatic bus(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input bit expect_hit, output logic [31:0] rd);
      @(negedge clk);
      lmb.LMB_ABus        = addr;
      lmb.LMB_AddrStrobe  = 1'b1;
      lmb.LMB_ReadStrobe  = ~wr;
      lmb.LMB_WriteStrobe = wr;
      lmb.LMB_WriteDBus   = wd;
      lmb.LMB_BE          = be;
      @(negedge clk);
      lmb.LMB_AddrStrobe  = 1'b0;
      lmb.LMB_ReadStrobe  = 1'b0;
      lmb.LMB_WriteStrobe = 1'b0;
      check("ready_hi", {63'd0, lmb.Sl_Ready}, {63'd0, expect_hit});
      rd = lmb.Sl_DBus;
      @(negedge clk);
      check("ready_lo", {63'd0, lmb.Sl_Ready}, 64'd0);
      check("dbus_idle", {32'd0, lmb.Sl_DBus}, 64'd0);
   endtask

   task automatic reg_rd(input int off, output logic [31:0] rd);
      bus(1'b0, BASE + 32'(off * 4), 32'd0, 4'hF, 1'b1, rd);
   endtask

   task automatic reg_wr(input int off, input logic [31:0] wd, input logic [3:0] be);
      logic [31:0] dummy;
      bus(1'b1, BASE + 32'(off * 4), wd, be, 1'b1, dummy);
   endtask

   task automatic cr_write(input logic [31:0] v);
      reg_wr(0, v, 4'hF);
      m_cr = v & 32'h0000_1F1B;
   endtask

   task automatic tx_write(input logic [31:0] v);
      reg_wr(3, v, 4'hF);
      m_txdr = v;
      m_txe  = 0;
   endtask

   task automatic sr_check(input string tag);
      logic [31:0] rd;
      reg_rd(1, rd);
      check(tag, {32'd0, rd}, {59'd0, m_udr, 1'b0, m_ovr, m_txe, m_rxv});
   endtask

   task automatic rx_read(input string tag);
      logic [31:0] rd;
      reg_rd(2, rd);
      check(tag, {32'd0, rd}, {32'd0, m_rxdr});
      m_rxv = 0;
   endtask

   task automatic sticky_clear();
      reg_wr(1, 32'h14, 4'h1);
      m_ovr = 0;
      m_udr = 0;
   endtask

   // Model of a TX load: the pending word, or zeros and an underrun if none is pending.
   task automatic model_load(output logic [31:0] txw);
      if (m_txe) begin
         txw   = 32'd0;
         m_udr = 1;
      end else begin
         txw = m_txdr;
      end
      m_txe = 1;
   endtask

   // SPI master: nbits bits MSB-first from mosi_w with SS held low throughout.
   // Frames of len+1 bits follow back to back; MISO is collected and compared at the end.
   task automatic spi_xfer(input bit cpol, input bit cpha, input int len, input int nbits,
                           input logic [63:0] mosi_w, input string tag);
      logic [63:0] got, exp;
      logic [31:0] txw, rxw;
      int          k;
      bit          b;
      got = 0; exp = 0; rxw = 0;
      SCLK = cpol; MOSI = 1'b0;
      #(H);
      SS = 1'b0;
      model_load(txw);
      for (int i = 0; i < nbits; i++) begin
         k = i % (len + 1);
         b = mosi_w[nbits - 1 - i];
         exp = {exp[62:0], txw[len - k]};
         if (!cpha) begin
            MOSI = b;
            #(H); SCLK = ~cpol; got = {got[62:0], MISO};
            #(H); SCLK = cpol;
         end else begin
            #(H); SCLK = ~cpol; MOSI = b;
            #(H); SCLK = cpol; got = {got[62:0], MISO};
         end
         rxw = {rxw[30:0], b};
         if (k == len) begin
            if (m_rxv) m_ovr = 1;
            m_rxdr = rxw;
            m_rxv  = 1;
            rxw    = 0;
            model_load(txw);
         end
      end
      #(H); SS = 1'b1;
      #(4 * H);
      check(tag, got, exp);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] tx;
      logic [63:0] mw;
      int          len;
      bit          cpol, cpha;

      rst_n = 1'b0;
      SCLK = 1'b0; MOSI = 1'b0; SS = 1'b1;
      lmb.LMB_ABus = '0; lmb.LMB_AddrStrobe = 1'b0; lmb.LMB_BE = '0;
      lmb.LMB_ReadStrobe = 1'b0; lmb.LMB_WriteStrobe = 1'b0; lmb.LMB_WriteDBus = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_miso_t", {63'd0, MISO_T}, 64'd1);
      check("rst_miso", {63'd0, MISO}, 64'd0);
      check("rst_irq", {63'd0, IRQ}, 64'd0);
      check("rst_ready", {63'd0, lmb.Sl_Ready}, 64'd0);
      check("rst_dbus", {32'd0, lmb.Sl_DBus}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // register reset values and decode
      reg_rd(0, rd); check("cr_reset", {32'd0, rd}, 64'h1F00);
      sr_check("sr_reset");
      reg_rd(2, rd); check("rxdr_reset", {32'd0, rd}, 64'd0);
      reg_rd(3, rd); check("txdr_reset", {32'd0, rd}, 64'd0);
      reg_wr(5, 32'hFFFF_FFFF, 4'hF);
      reg_rd(5, rd); check("reserved_rd", {32'd0, rd}, 64'd0);
      bus(1'b0, BASE + 32'h20, 32'd0, 4'hF, 1'b0, rd);

      // mode 0, 8-bit frame, RX interrupt enabled
      cr_write(32'h0000_0708);
      tx_write(32'h0000_00A5);
      sr_check("sr_tx_pending");
      spi_xfer(1'b0, 1'b0, 7, 8, 64'h3C, "m0_miso");
      check("m0_irq_rx", {63'd0, IRQ}, 64'd1);
      sr_check("m0_sr");
      rx_read("m0_rxdr");
      check("m0_irq_clr", {63'd0, IRQ}, 64'd0);
      sticky_clear();

      // mode 3, 32-bit frame
      cr_write(32'h0000_1F03);
      tx_write(32'hDEAD_BEEF);
      spi_xfer(1'b1, 1'b1, 31, 32, 64'h1234_5678, "m3_miso");
      sr_check("m3_sr");
      rx_read("m3_rxdr");
      sticky_clear();

      // two back-to-back 8-bit frames, mode 1: overrun and underrun
      cr_write(32'h0000_0701);
      tx_write($urandom_range(0, 255));
      mw = 64'($urandom_range(0, 65535));
      spi_xfer(1'b0, 1'b1, 7, 16, mw, "ovr_miso");
      sr_check("ovr_sr");
      rx_read("ovr_rxdr");
      sticky_clear();
      sr_check("sticky_clr_sr");

      // aborted frame after 5 bits, then a full frame (mode 2)
      cr_write(32'h0000_0702);
      tx_write($urandom_range(0, 255));
      spi_xfer(1'b1, 1'b0, 7, 5, 64'($urandom_range(0, 31)), "abort_miso");
      sr_check("abort_sr");
      tx_write($urandom_range(0, 255));
      spi_xfer(1'b1, 1'b0, 7, 8, 64'($urandom_range(0, 255)), "after_abort_miso");
      sr_check("after_abort_sr");
      rx_read("after_abort_rxdr");
      sticky_clear();

      // CR byte enables: only byte 0 written, only defined bits stick
      reg_wr(0, 32'hFFFF_FFFF, 4'b0001);
      reg_rd(0, rd); check("cr_be", {32'd0, rd}, 64'h071B);
      cr_write(32'h0000_0702);
      check("irq_off", {63'd0, IRQ}, 64'd0);
      cr_write(32'h0000_0712);
      check("irq_tx", {63'd0, IRQ}, 64'd1);

      // randomized frames: length, mode, pending TX word, frame count and RX reads vary
      for (int it = 0; it < 6; it++) begin
         len  = $urandom_range(0, 15);
         cpol = 1'($urandom_range(0, 1));
         cpha = 1'($urandom_range(0, 1));
         cr_write({19'd0, 5'(len), 6'd0, cpol, cpha});
         if ($urandom_range(0, 3) != 0) tx_write($urandom);
         mw = {$urandom, $urandom};
         spi_xfer(cpol, cpha, len, (len + 1) * $urandom_range(1, 2), mw, "rand_miso");
         sr_check("rand_sr");
         if ($urandom_range(0, 1) != 0) rx_read("rand_rxdr");
         sticky_clear();
      end

      // reset asserted in the middle of a frame
      rx_read("pre_rst_rxdr");
      cr_write(32'h0000_0710);
      tx_write(32'h0000_005A);
      check("pre_rst_irq", {63'd0, IRQ}, 64'd0);
      SCLK = 1'b0; SS = 1'b0;
      #(H); SCLK = 1'b1; #(H); SCLK = 1'b0; #(H); SCLK = 1'b1; #(H);
      check("mid_irq", {63'd0, IRQ}, 64'd1);
      check("mid_miso_t", {63'd0, MISO_T}, 64'd0);
      #3 rst_n = 1'b0;
      #1;
      check("arst_miso_t", {63'd0, MISO_T}, 64'd1);
      check("arst_miso", {63'd0, MISO}, 64'd0);
      check("arst_irq", {63'd0, IRQ}, 64'd0);
      check("arst_ready", {63'd0, lmb.Sl_Ready}, 64'd0);
      SS = 1'b1; SCLK = 1'b0;
      #20 rst_n = 1'b1;
      model_reset();
      sr_check("post_rst_sr");
      reg_rd(0, rd); check("post_rst_cr", {32'd0, rd}, 64'h1F00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
